// File: rtl/l2_cache_arb_pkg.sv
// Shared L2 request packet type, op encodings and sizing constants used by the
// L2 arbitration stage and its round-robin arbiter.
`timescale 1ns/1ps
package l2_cache_arb_pkg;

  localparam int L2_NUM_CORES        = 4;
  localparam int L2_CORE_INDEX_WIDTH = 2;
  localparam int CACHE_LINE_BITS     = 512;
  localparam int L2_ADDR_WIDTH       = 26;

  typedef enum logic [2:0] {
    L2REQ_LOAD        = 3'd0,
    L2REQ_STORE       = 3'd1,
    L2REQ_FLUSH       = 3'd2,
    L2REQ_DINVALIDATE = 3'd3,
    L2REQ_IINVALIDATE = 3'd4,
    L2REQ_LOAD_SYNC   = 3'd5,
    L2REQ_STORE_SYNC  = 3'd6
  } l2req_op_t;

  typedef struct packed {
    logic                           valid;
    logic [L2_CORE_INDEX_WIDTH-1:0] core;
    logic [1:0]                     id;
    l2req_op_t                      op;
    logic [L2_ADDR_WIDTH-1:0]       address;
  } l2req_packet_t;

  // Flush and D-invalidate never go to memory, so they can never come back as a fill.
  function automatic logic is_fill_op_legal(input l2req_op_t op);
    return (op != L2REQ_FLUSH) && (op != L2REQ_DINVALIDATE);
  endfunction

endpackage

// File: rtl/l2_cache_arb_arbiter_rr.sv
// NUM_CORES-wide round-robin arbiter; owns rr_ptr, which advances past the
// winner only when the caller says the grant was actually taken.
`timescale 1ns/1ps
module l2_cache_arb_arbiter_rr
  import l2_cache_arb_pkg::*;
#(
  parameter int NUM_CORES = L2_NUM_CORES
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_CORES-1:0] request,
  input  logic                 update_en,
  output logic [NUM_CORES-1:0] grant
);

  localparam int PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_CORES - 1);

  logic [PTR_W-1:0] rr_ptr_q;
  logic [PTR_W-1:0] rr_ptr_d;
  logic [PTR_W-1:0] winner;
  int               idx;

  // Scan from the far end back toward rr_ptr so the closest requester is written last.
  always_comb begin
    grant  = '0;
    winner = rr_ptr_q;
    idx    = 0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      idx = (int'(rr_ptr_q) + i) % NUM_CORES;
      if (request[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
        winner     = PTR_W'(idx);
      end else begin
        winner = winner;
      end
    end
  end

  always_comb begin
    if (update_en && (|request)) begin
      if (winner == LAST_IDX) begin
        rr_ptr_d = '0;
      end else begin
        rr_ptr_d = winner + PTR_W'(1);
      end
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

endmodule

// File: rtl/l2_cache_arb_checker.sv
// Protocol checks for the L2 arbiter: legal restart packets and well-formed acks.
`timescale 1ns/1ps
module l2_cache_arb_checker
  import l2_cache_arb_pkg::*;
#(
  parameter int NUM_CORES = L2_NUM_CORES
) (
  input logic                 clk,
  input logic                 reset,
  input logic                 restart_valid,
  input l2req_packet_t        restart_packet,
  input logic [NUM_CORES-1:0] core_request_valid,
  input logic [NUM_CORES-1:0] core_request_ack,
  input logic                 restart_ack
);

  a_restart_op_legal: assert property (@(posedge clk) disable iff (reset)
    restart_valid |-> is_fill_op_legal(restart_packet.op));

  a_restart_pkt_valid: assert property (@(posedge clk) disable iff (reset)
    restart_valid |-> restart_packet.valid);

  a_ack_onehot0: assert property (@(posedge clk)
    $onehot0({restart_ack, core_request_ack}));

  a_ack_needs_valid: assert property (@(posedge clk)
    ((core_request_ack & ~core_request_valid) == '0) && (!restart_ack || restart_valid));

endmodule

// File: rtl/l2_cache_arb.sv
// L2 pipeline stage 1: fill/core priority mux plus output register to the tag stage.
// Optional fill-burst fairness is enabled by defining L2_ARB_FAIR_FILL_EN.
`timescale 1ns/1ps
module l2_cache_arb
  import l2_cache_arb_pkg::*;
#(
  parameter int NUM_CORES      = L2_NUM_CORES,
  parameter int FILL_BURST_MAX = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_CORES-1:0]              core_request_valid,
  input  l2req_packet_t [NUM_CORES-1:0]     core_request,
  output logic [NUM_CORES-1:0]              core_request_ack,
  input  logic                              restart_valid,
  input  l2req_packet_t                     restart_packet,
  input  logic [CACHE_LINE_BITS-1:0]        restart_data,
  output logic                              restart_ack,
  input  logic                              stall_pipeline,
  output l2req_packet_t                     arb_l2req_packet,
  output logic                              arb_is_l2_fill,
  output logic [CACHE_LINE_BITS-1:0]        arb_data_from_memory
);

  localparam int PKT_W = $bits(l2req_packet_t);

  if (FILL_BURST_MAX < 1) begin : g_bad_fill_burst_max
    $error("FILL_BURST_MAX must be at least 1");
  end

  logic [NUM_CORES-1:0]       rr_grant;
  logic                       any_core;
  logic                       fair_block;
  logic                       fill_grant;
  logic                       core_grant;
  l2req_packet_t              core_pkt;
  l2req_packet_t              arb_pkt_q, arb_pkt_d;
  logic                       arb_fill_q, arb_fill_d;
  logic [CACHE_LINE_BITS-1:0] arb_data_q, arb_data_d;

  assign any_core = |core_request_valid;

  l2_cache_arb_arbiter_rr #(.NUM_CORES(NUM_CORES)) u_arbiter_rr (
    .clk       (clk),
    .reset     (reset),
    .request   (core_request_valid),
    .update_en (core_grant),
    .grant     (rr_grant)
  );

`ifdef L2_ARB_FAIR_FILL_EN
  localparam int FB_W = $clog2(FILL_BURST_MAX + 1);
  logic [FB_W-1:0] fill_burst_q, fill_burst_d;

  assign fair_block = any_core && (fill_burst_q == FB_W'(FILL_BURST_MAX));

  // Count only fills that made a core wait; any core grant or uncontended fill clears it.
  always_comb begin
    if (core_grant) begin
      fill_burst_d = '0;
    end else if (fill_grant && any_core) begin
      fill_burst_d = fill_burst_q + FB_W'(1);
    end else if (fill_grant) begin
      fill_burst_d = '0;
    end else begin
      fill_burst_d = fill_burst_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fill_burst_q <= '0;
    end else begin
      fill_burst_q <= fill_burst_d;
    end
  end
`else
  assign fair_block = 1'b0;
`endif

  always_comb begin
    fill_grant = 1'b0;
    core_grant = 1'b0;
    if (stall_pipeline || reset) begin
      fill_grant = 1'b0;
    end else if (restart_valid && !fair_block) begin
      fill_grant = 1'b1;
    end else if (any_core) begin
      core_grant = 1'b1;
    end else begin
      core_grant = 1'b0;
    end
  end

  assign restart_ack      = fill_grant;
  assign core_request_ack = core_grant ? rr_grant : '0;

  always_comb begin
    core_pkt = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      core_pkt = core_pkt | (core_request[i] & {PKT_W{rr_grant[i]}});
    end
  end

  // A cycle without a grant registers a bubble; fill data is only replaced by a new fill.
  always_comb begin
    arb_pkt_d  = arb_pkt_q;
    arb_fill_d = 1'b0;
    arb_data_d = arb_data_q;
    if (fill_grant) begin
      arb_pkt_d       = restart_packet;
      arb_pkt_d.valid = 1'b1;
      arb_fill_d      = 1'b1;
      arb_data_d      = restart_data;
    end else if (core_grant) begin
      arb_pkt_d       = core_pkt;
      arb_pkt_d.valid = 1'b1;
    end else begin
      arb_pkt_d.valid = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      arb_pkt_q  <= '0;
      arb_fill_q <= 1'b0;
      arb_data_q <= '0;
    end else begin
      arb_pkt_q  <= arb_pkt_d;
      arb_fill_q <= arb_fill_d;
      arb_data_q <= arb_data_d;
    end
  end

  assign arb_l2req_packet     = arb_pkt_q;
  assign arb_is_l2_fill       = arb_fill_q;
  assign arb_data_from_memory = arb_data_q;

  l2_cache_arb_checker #(.NUM_CORES(NUM_CORES)) u_checker (
    .clk                (clk),
    .reset              (reset),
    .restart_valid      (restart_valid),
    .restart_packet     (restart_packet),
    .core_request_valid (core_request_valid),
    .core_request_ack   (core_request_ack),
    .restart_ack        (restart_ack)
  );

endmodule

// File: tb/tb_l2_cache_arb.sv
// Self-checking bench for l2_cache_arb: directed vector table, hand-written corner
// sequences and a randomized run against a queue-style reference model.
`timescale 1ns/1ps
module tb_l2_cache_arb;
  import l2_cache_arb_pkg::*;

  localparam int NC  = 4;
  localparam int FBM = 4;
  localparam int LW  = CACHE_LINE_BITS;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   reset;
  logic [NC-1:0]          core_request_valid;
  l2req_packet_t [NC-1:0] core_request;
  logic [NC-1:0]          core_request_ack;
  logic                   restart_valid;
  l2req_packet_t          restart_packet;
  logic [LW-1:0]          restart_data;
  logic                   restart_ack;
  logic                   stall_pipeline;
  l2req_packet_t          arb_l2req_packet;
  logic                   arb_is_l2_fill;
  logic [LW-1:0]          arb_data_from_memory;

  l2_cache_arb #(.NUM_CORES(NC), .FILL_BURST_MAX(FBM)) dut (
    .clk                  (clk),
    .reset                (reset),
    .core_request_valid   (core_request_valid),
    .core_request         (core_request),
    .core_request_ack     (core_request_ack),
    .restart_valid        (restart_valid),
    .restart_packet       (restart_packet),
    .restart_data         (restart_data),
    .restart_ack          (restart_ack),
    .stall_pipeline       (stall_pipeline),
    .arb_l2req_packet     (arb_l2req_packet),
    .arb_is_l2_fill       (arb_is_l2_fill),
    .arb_data_from_memory (arb_data_from_memory)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state: next core to favour, fill streak, and what the tag stage should see.
  int            m_rr;
  int            m_burst;
  l2req_packet_t m_pkt;
  logic          m_fill;
  logic [LW-1:0] m_data;

  typedef struct {
    logic          rst;
    logic          stall;
    logic [NC-1:0] cv;
    logic          rv;
    logic [NC-1:0] exp_core;
    logic          exp_restart;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [639:0] act, input logic [639:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic l2req_packet_t rand_pkt(input int core);
    l2req_packet_t p;
    p.valid   = 1'b1;
    p.core    = 2'(core);
    p.id      = 2'($urandom_range(0, 3));
    p.op      = ($urandom_range(0, 1) == 0) ? L2REQ_LOAD : L2REQ_STORE;
    p.address = 26'($urandom());
    return p;
  endfunction

  task automatic drive(input logic r, input logic st, input logic [NC-1:0] cv, input logic rv);
    reset              = r;
    stall_pipeline     = st;
    core_request_valid = cv;
    restart_valid      = rv;
    for (int i = 0; i < NC; i++) core_request[i] = rand_pkt(i);
    restart_packet = rand_pkt(0);
    for (int w = 0; w < LW / 32; w++) restart_data[w*32 +: 32] = $urandom();
  endtask

  // -1 = nothing granted, -2 = restart, otherwise the core index.
  function automatic int model_pick();
    int order[$];
    int pick;
    bit any;
    bit block;
    any   = (core_request_valid != '0);
    block = 1'b0;
`ifdef L2_ARB_FAIR_FILL_EN
    block = any && (m_burst == FBM);
`endif
    if (reset || stall_pipeline) return -1;
    if (restart_valid && !block) return -2;
    for (int i = 0; i < NC; i++) order.push_back((m_rr + i) % NC);
    pick = -1;
    foreach (order[j]) if (pick < 0 && core_request_valid[order[j]]) pick = order[j];
    return pick;
  endfunction

  // One clock: check acks mid-cycle, advance the model at the edge, check registers just after.
  task automatic cycle(output logic [NC:0] ack_seen);
    int pick;
    bit any;
    logic [NC:0] exp_ack;
    #4;
    pick    = model_pick();
    any     = (core_request_valid != '0);
    exp_ack = '0;
    if (pick == -2) exp_ack[NC] = 1'b1;
    else if (pick >= 0) exp_ack[pick] = 1'b1;
    ack_seen = {restart_ack, core_request_ack};
    check("acks_vs_model", ack_seen, exp_ack);
    @(posedge clk);
    if (reset) begin
      m_rr = 0; m_burst = 0; m_pkt = '0; m_fill = 1'b0; m_data = '0;
    end else if (pick == -2) begin
      m_pkt = restart_packet; m_pkt.valid = 1'b1; m_fill = 1'b1; m_data = restart_data;
      m_burst = any ? m_burst + 1 : 0;
    end else if (pick >= 0) begin
      m_pkt = core_request[pick]; m_pkt.valid = 1'b1; m_fill = 1'b0;
      m_rr = (pick + 1) % NC; m_burst = 0;
    end else begin
      m_pkt.valid = 1'b0; m_fill = 1'b0;
    end
    #1;
    check("pkt_vs_model", arb_l2req_packet, m_pkt);
    check("fill_vs_model", arb_is_l2_fill, m_fill);
    check("data_vs_model", arb_data_from_memory, m_data);
  endtask

  initial begin
    logic [NC:0]   ack;
    logic [LW-1:0] a5_line;
    logic [NC:0]   fair_exp[6];

    vecs[0]  = '{1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 4'b0100, 1'b0, 4'b0100, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 4'b1111, 1'b0, 4'b1000, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 4'b1111, 1'b0, 4'b0001, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 4'b1111, 1'b0, 4'b0010, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 4'b1111, 1'b0, 4'b0100, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 4'b1111, 1'b0, 4'b1000, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 4'b0010, 1'b1, 4'b0000, 1'b1};
    vecs[8]  = '{1'b0, 1'b0, 4'b0010, 1'b0, 4'b0010, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 4'b1111, 1'b0, 4'b0000, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 4'b1111, 1'b1, 4'b0000, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 4'b1111, 1'b0, 4'b0100, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 4'b0001, 1'b0, 4'b0001, 1'b0};
    vecs[13] = '{1'b1, 1'b0, 4'b1111, 1'b1, 4'b0000, 1'b0};
    vecs[14] = '{1'b0, 1'b0, 4'b1111, 1'b0, 4'b0001, 1'b0};

    drive(1'b1, 1'b0, 4'b0000, 1'b0);
    @(posedge clk);
    #1;
    m_rr = 0; m_burst = 0; m_pkt = '0; m_fill = 1'b0; m_data = '0;
    cycle(ack);
    check("reset_pkt", arb_l2req_packet, 34'd0);
    check("reset_fill", arb_is_l2_fill, 1'b0);
    check("reset_data", arb_data_from_memory, 512'd0);

    for (int v = 0; v < 15; v++) begin
      drive(vecs[v].rst, vecs[v].stall, vecs[v].cv, vecs[v].rv);
      cycle(ack);
      check($sformatf("vec%0d_acks", v), ack, {vecs[v].exp_restart, vecs[v].exp_core});
      if (v == 1) begin
        check("core2_out_valid", arb_l2req_packet.valid, 1'b1);
        check("core2_out_fill", arb_is_l2_fill, 1'b0);
      end
    end

    // Fill beats a pending core1 and carries the memory line.
    a5_line = {64{8'hA5}};
    drive(1'b0, 1'b0, 4'b0010, 1'b1);
    restart_data = a5_line;
    cycle(ack);
    check("fill_a5_ack", ack, 5'b10000);
    check("fill_a5_is_fill", arb_is_l2_fill, 1'b1);
    check("fill_a5_data", arb_data_from_memory, a5_line);
    drive(1'b0, 1'b0, 4'b0010, 1'b0);
    cycle(ack);
    check("after_fill_core1", ack, 5'b00010);
    check("after_fill_keeps_data", arb_data_from_memory, a5_line);

    // Three stalled cycles: no acks, bubbles, rotation resumes where it left off.
    drive(1'b0, 1'b0, 4'b0100, 1'b0);
    cycle(ack);
    check("pre_stall_core2", ack, 5'b00100);
    for (int s = 0; s < 3; s++) begin
      drive(1'b0, 1'b1, 4'b1111, 1'b0);
      cycle(ack);
      check("stall_no_ack", ack, 5'b00000);
      check("stall_bubble", arb_l2req_packet.valid, 1'b0);
    end
    drive(1'b0, 1'b0, 4'b1111, 1'b0);
    cycle(ack);
    check("post_stall_core3", ack, 5'b01000);
    drive(1'b0, 1'b0, 4'b1111, 1'b0);
    cycle(ack);
    check("post_stall_core0", ack, 5'b00001);

    // Reset right after a grant clears outputs and the round-robin pointer.
    drive(1'b0, 1'b0, 4'b0010, 1'b0);
    cycle(ack);
    check("pre_reset_core1", ack, 5'b00010);
    drive(1'b1, 1'b0, 4'b1111, 1'b1);
    cycle(ack);
    check("reset_no_ack", ack, 5'b00000);
    check("reset_mid_pkt", arb_l2req_packet, 34'd0);
    check("reset_mid_fill", arb_is_l2_fill, 1'b0);
    check("reset_mid_data", arb_data_from_memory, 512'd0);
    drive(1'b0, 1'b0, 4'b1111, 1'b0);
    cycle(ack);
    check("after_reset_core0", ack, 5'b00001);

    // Restart held high with core0 pending.
`ifdef L2_ARB_FAIR_FILL_EN
    fair_exp = '{5'b10000, 5'b10000, 5'b10000, 5'b10000, 5'b00001, 5'b10000};
`else
    fair_exp = '{5'b10000, 5'b10000, 5'b10000, 5'b10000, 5'b10000, 5'b10000};
`endif
    for (int f = 0; f < 6; f++) begin
      drive(1'b0, 1'b0, 4'b0001, 1'b1);
      cycle(ack);
      check($sformatf("fill_burst_%0d", f), ack, fair_exp[f]);
    end

    for (int r = 0; r < 600; r++) begin
      drive(($urandom_range(0, 49) == 0), ($urandom_range(0, 7) == 0),
            4'($urandom_range(0, 15)), ($urandom_range(0, 1) == 1));
      cycle(ack);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
